alu_lockstep_sched: RTL and testbench
=====================================

Name: alu_lockstep_sched

Overview:
- Front-end scheduler for the dual-redundant 8-bit ALU pair (two identical ALU copies whose outputs are XOR-compared).
- Arbitrates round-robin between two requesters and issues each accepted op to both ALU copies with identical operands.
- Compares the two results and retries on mismatch; after retries are exhausted, returns an error response and logs a fault.
- The ALU pair sits outside this block, so benches can inject mismatches on the result inputs.

Parameters:
- DATA_W, 8, operand/result width.
- MAX_RETRY, 2, re-executions allowed after the first mismatching attempt.
- CNT_W, 8, width of the saturating fault counter.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous reset, active-high
- req0_valid  in  1  requester 0 op valid
- req0_ready  out  1  requester 0 op accepted this cycle
- req0_a, req0_b  in  DATA_W  requester 0 operands
- req0_sel  in  2  op: 00 add, 01 sub, 10 and, 11 or
- req1_valid, req1_ready, req1_a, req1_b, req1_sel  same as req0, for requester 1
- rsp_valid  out  1  response valid
- rsp_ready  in  1  response consumer ready
- rsp_id  out  1  requester index of response
- rsp_data  out  DATA_W  result (ALU copy 1)
- rsp_carry  out  1  carry (ALU copy 1)
- rsp_err  out  1  lockstep mismatch persisted after all retries
- alu_a0, alu_b0, alu_a1, alu_b1  out  DATA_W  operands to ALU copies 1/2
- alu_sel1, alu_sel2  out  2  selects to ALU copies 1/2
- alu_out1, alu_out2  in  DATA_W  ALU copy results
- alu_carry1, alu_carry2  in  1  ALU copy carries
- fault_sticky  out  1  set on any error response; cleared only by fault_clr
- fault_clr  in  1  clears fault_sticky and fault_count
- fault_count  out  CNT_W  error responses since last clear; saturates at all-ones

Behaviour:
- Reset values:
  - State IDLE; all ready/valid outputs 0.
  - rsp_id/data/carry/err 0; operand registers 0, so alu_* outputs are 0.
  - Retry counter 0; RR pointer favours req0; fault_sticky 0; fault_count 0.
- States:
  - IDLE: if any reqX_valid, assert ready combinationally to exactly one winner. On handshake, capture a/b/sel/id and go to EXEC with retry=0.
  - EXEC: ALU outputs are driven from the captured registers (both copies identical). At the clock edge, compare {alu_carry1,alu_out1} against {alu_carry2,alu_out2}.
    - Match -> RESP with err=0.
    - Mismatch and retry<MAX_RETRY -> retry+1, stay in EXEC.
    - Mismatch and retry==MAX_RETRY -> RESP with err=1.
  - RESP: rsp_valid=1; rsp_* registered from the final EXEC cycle and held stable until rsp_ready. On handshake go to IDLE.
- Arbitration:
  - Both valid: grant the requester not granted last; after reset, req0 wins.
  - Single valid: grant it. The pointer updates only on an accepted handshake.
- No ready is asserted outside IDLE; one op in flight.
- Latency: accept at cycle N; rsp_valid at N+2 with no mismatch; each retry adds 1. Maximum N+2+MAX_RETRY.
- Minimum 3 cycles per op (IDLE, EXEC, RESP with rsp_ready=1).
- Mismatch-then-match within the retry budget gives err=0 and no fault logged.
- alu_* outputs hold the last op's operands while idle.
- Error response:
  - fault_sticky set and fault_count incremented (saturating), in the cycle RESP is entered.
  - fault_clr in the same cycle as a new error: the error wins (sticky=1, count=1).
- rsp_data/rsp_carry on err reflect copy 1 of the final attempt.
- Reset mid-op: in-flight op dropped, no response, all state to reset values immediately.
- Sum/difference width: DATA_W+1 bits out of the ALU; carry is the MSB; this block only compares and forwards.

Decomposition:
- Shared package:
  - ALU op encoding constants OP_ADD=2'b00, OP_SUB=2'b01, OP_AND=2'b10, OP_OR=2'b11.
  - State typedef {IDLE, EXEC, RESP}.
- Sub-module rr_arb2: 2-way round-robin arbiter with a grant-pointer register. Everything else lives inline.

Test Plan:
- req0 a=8'hF0, b=8'h20, sel=00; ALUs agree -> rsp at N+2: id=0, data=8'h10, carry=1, err=0; fault_count=0.
- req0 and req1 both valid continuously, four ops each, rsp_ready=1 -> grants alternate 0,1,0,1…, starting with 0.
- One-cycle injected mismatch: alu_out2 ^= 8'h01 in the first EXEC only -> rsp at N+3, err=0, fault_sticky=0.
- Persistent mismatch with MAX_RETRY=2 -> rsp at N+4, err=1, fault_sticky=1, fault_count=1.
  - Then pulse fault_clr -> both return to 0.
- rsp_ready held low 5 cycles -> rsp_* stable, req ready stays 0; rsp_ready=1 -> IDLE next cycle.
- Assert rst during EXEC -> no rsp_valid, outputs zero; the next op after deassertion completes normally.

Source files
------------

// File: rtl/alu_lockstep_sched_pkg.sv
// Shared definitions for the lockstep ALU scheduler: op encodings and FSM states.
package alu_lockstep_sched_pkg;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_AND = 2'b10;
  localparam logic [1:0] OP_OR  = 2'b11;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    EXEC = 2'b01,
    RESP = 2'b10
  } state_t;

endpackage

// File: rtl/alu_lockstep_sched_rr_arb2.sv
// Two-way round-robin arbiter; the pointer moves only when a grant is issued,
// and a grant is only issued to a valid requester, so every grant is a handshake.
module rr_arb2 (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_en,
  input  logic [1:0] i_req,
  output logic [1:0] o_grant
);

  logic r_prio;  // 0: req0 preferred on contention, 1: req1 preferred

  // Grant selection: only while enabled, contention resolved by the pointer.
  always_comb begin
    o_grant = 2'b00;
    if (!i_en) begin
      o_grant = 2'b00;
    end else if (i_req == 2'b11) begin
      o_grant = r_prio ? 2'b10 : 2'b01;
    end else begin
      o_grant = i_req;
    end
  end

  // Pointer update: favour the requester that was not just served.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_prio <= 1'b0;
    end else if (|o_grant) begin
      r_prio <= o_grant[0];
    end else begin
      r_prio <= r_prio;
    end
  end

endmodule

// File: rtl/alu_lockstep_sched.sv
// Scheduler for a dual-redundant ALU pair: arbitrates two requesters, issues each op
// to both copies, retries on result mismatch and reports/logs persistent faults.
module alu_lockstep_sched
  import alu_lockstep_sched_pkg::*;
#(
  parameter int DATA_W    = 8,
  parameter int MAX_RETRY = 2,
  parameter int CNT_W     = 8
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_req0_valid,
  output logic              o_req0_ready,
  input  logic [DATA_W-1:0] i_req0_a,
  input  logic [DATA_W-1:0] i_req0_b,
  input  logic [1:0]        i_req0_sel,
  input  logic              i_req1_valid,
  output logic              o_req1_ready,
  input  logic [DATA_W-1:0] i_req1_a,
  input  logic [DATA_W-1:0] i_req1_b,
  input  logic [1:0]        i_req1_sel,
  output logic              o_rsp_valid,
  input  logic              i_rsp_ready,
  output logic              o_rsp_id,
  output logic [DATA_W-1:0] o_rsp_data,
  output logic              o_rsp_carry,
  output logic              o_rsp_err,
  output logic [DATA_W-1:0] o_alu_a0,
  output logic [DATA_W-1:0] o_alu_b0,
  output logic [DATA_W-1:0] o_alu_a1,
  output logic [DATA_W-1:0] o_alu_b1,
  output logic [1:0]        o_alu_sel1,
  output logic [1:0]        o_alu_sel2,
  input  logic [DATA_W-1:0] i_alu_out1,
  input  logic [DATA_W-1:0] i_alu_out2,
  input  logic              i_alu_carry1,
  input  logic              i_alu_carry2,
  output logic              o_fault_sticky,
  input  logic              i_fault_clr,
  output logic [CNT_W-1:0]  o_fault_count
);

  localparam int RW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

  state_t            r_state;
  logic [DATA_W-1:0] r_a;
  logic [DATA_W-1:0] r_b;
  logic [1:0]        r_sel;
  logic              r_id;
  logic [RW-1:0]     r_retry;
  logic              r_rsp_valid;
  logic              r_rsp_id;
  logic [DATA_W-1:0] r_rsp_data;
  logic              r_rsp_carry;
  logic              r_rsp_err;
  logic              r_fault_sticky;
  logic [CNT_W-1:0]  r_fault_count;

  logic [1:0] w_grant;
  logic       w_mismatch;
  logic       w_retry_done;
  logic       w_err_now;

  rr_arb2 u_arb (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_en    (r_state == IDLE),
    .i_req   ({i_req1_valid, i_req0_valid}),
    .o_grant (w_grant)
  );

  assign w_mismatch   = {i_alu_carry1, i_alu_out1} != {i_alu_carry2, i_alu_out2};
  assign w_retry_done = (r_retry == RW'(MAX_RETRY));
  assign w_err_now    = (r_state == EXEC) && w_mismatch && w_retry_done;

  // Op sequencing: capture on grant, execute/compare with retries, hold response.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state     <= IDLE;
      r_a         <= '0;
      r_b         <= '0;
      r_sel       <= 2'b00;
      r_id        <= 1'b0;
      r_retry     <= '0;
      r_rsp_valid <= 1'b0;
      r_rsp_id    <= 1'b0;
      r_rsp_data  <= '0;
      r_rsp_carry <= 1'b0;
      r_rsp_err   <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (|w_grant) begin
            r_id    <= w_grant[1];
            r_a     <= w_grant[1] ? i_req1_a   : i_req0_a;
            r_b     <= w_grant[1] ? i_req1_b   : i_req0_b;
            r_sel   <= w_grant[1] ? i_req1_sel : i_req0_sel;
            r_retry <= '0;
            r_state <= EXEC;
          end else begin
            r_state <= IDLE;
          end
        end
        EXEC: begin
          if (!w_mismatch || w_retry_done) begin
            r_state     <= RESP;
            r_rsp_valid <= 1'b1;
            r_rsp_id    <= r_id;
            r_rsp_data  <= i_alu_out1;
            r_rsp_carry <= i_alu_carry1;
            r_rsp_err   <= w_mismatch;
          end else begin
            r_retry <= r_retry + RW'(1);
          end
        end
        RESP: begin
          if (i_rsp_ready) begin
            r_rsp_valid <= 1'b0;
            r_state     <= IDLE;
          end else begin
            r_state <= RESP;
          end
        end
        default: begin
          r_state     <= IDLE;
          r_rsp_valid <= 1'b0;
        end
      endcase
    end
  end

  // Fault log: a new error outranks a simultaneous clear.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_fault_sticky <= 1'b0;
      r_fault_count  <= '0;
    end else if (w_err_now) begin
      r_fault_sticky <= 1'b1;
      if (i_fault_clr) begin
        r_fault_count <= CNT_W'(1);
      end else if (r_fault_count != {CNT_W{1'b1}}) begin
        r_fault_count <= r_fault_count + CNT_W'(1);
      end else begin
        r_fault_count <= r_fault_count;
      end
    end else if (i_fault_clr) begin
      r_fault_sticky <= 1'b0;
      r_fault_count  <= '0;
    end else begin
      r_fault_sticky <= r_fault_sticky;
      r_fault_count  <= r_fault_count;
    end
  end

  assign o_req0_ready   = w_grant[0];
  assign o_req1_ready   = w_grant[1];
  assign o_rsp_valid    = r_rsp_valid;
  assign o_rsp_id       = r_rsp_id;
  assign o_rsp_data     = r_rsp_data;
  assign o_rsp_carry    = r_rsp_carry;
  assign o_rsp_err      = r_rsp_err;
  assign o_alu_a0       = r_a;
  assign o_alu_b0       = r_b;
  assign o_alu_a1       = r_a;
  assign o_alu_b1       = r_b;
  assign o_alu_sel1     = r_sel;
  assign o_alu_sel2     = r_sel;
  assign o_fault_sticky = r_fault_sticky;
  assign o_fault_count  = r_fault_count;

endmodule

// File: tb/tb_alu_lockstep_sched.sv
// Directed bench: models the external ALU pair with a mismatch injector on copy 2.
module tb_alu_lockstep_sched;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       req0_valid = 1'b0, req1_valid = 1'b0;
  logic       req0_ready, req1_ready;
  logic [7:0] req0_a = 8'h00, req0_b = 8'h00, req1_a = 8'h00, req1_b = 8'h00;
  logic [1:0] req0_sel = 2'b00, req1_sel = 2'b00;
  logic       rsp_valid, rsp_ready = 1'b0, rsp_id, rsp_carry, rsp_err;
  logic [7:0] rsp_data;
  logic [7:0] alu_a0, alu_b0, alu_a1, alu_b1, alu_out1, alu_out2;
  logic [1:0] alu_sel1, alu_sel2;
  logic       alu_carry1, alu_carry2;
  logic       fault_sticky, fault_clr = 1'b0;
  logic [7:0] fault_count;
  logic [7:0] inj_mask = 8'h00;
  int         inj_left = 0;
  int         checks = 0;
  int         failures = 0;

  always #5 clk = ~clk;

  function automatic logic [8:0] alu_f(input logic [7:0] a, input logic [7:0] b, input logic [1:0] s);
    case (s)
      2'b00:   alu_f = {1'b0, a} + {1'b0, b};
      2'b01:   alu_f = {1'b0, a} - {1'b0, b};
      2'b10:   alu_f = {1'b0, a & b};
      2'b11:   alu_f = {1'b0, a | b};
      default: alu_f = 9'h000;
    endcase
  endfunction

  assign {alu_carry1, alu_out1} = alu_f(alu_a0, alu_b0, alu_sel1);
  assign {alu_carry2, alu_out2} = alu_f(alu_a1, alu_b1, alu_sel2) ^ {1'b0, (inj_left != 0) ? inj_mask : 8'h00};

  alu_lockstep_sched dut (
    .i_clk(clk), .i_rst(rst),
    .i_req0_valid(req0_valid), .o_req0_ready(req0_ready), .i_req0_a(req0_a), .i_req0_b(req0_b), .i_req0_sel(req0_sel),
    .i_req1_valid(req1_valid), .o_req1_ready(req1_ready), .i_req1_a(req1_a), .i_req1_b(req1_b), .i_req1_sel(req1_sel),
    .o_rsp_valid(rsp_valid), .i_rsp_ready(rsp_ready), .o_rsp_id(rsp_id), .o_rsp_data(rsp_data),
    .o_rsp_carry(rsp_carry), .o_rsp_err(rsp_err),
    .o_alu_a0(alu_a0), .o_alu_b0(alu_b0), .o_alu_a1(alu_a1), .o_alu_b1(alu_b1),
    .o_alu_sel1(alu_sel1), .o_alu_sel2(alu_sel2),
    .i_alu_out1(alu_out1), .i_alu_out2(alu_out2), .i_alu_carry1(alu_carry1), .i_alu_carry2(alu_carry2),
    .o_fault_sticky(fault_sticky), .i_fault_clr(fault_clr), .o_fault_count(fault_count)
  );

  // Issues one op (called just after a negedge, DUT idle); lat = edges from accept to RESP, -1 on timeout.
  task automatic do_op(input logic which, input logic [7:0] a, input logic [7:0] b,
                       input logic [1:0] sel, output int lat);
    if (which) begin
      req1_valid = 1'b1; req1_a = a; req1_b = b; req1_sel = sel;
    end else begin
      req0_valid = 1'b1; req0_a = a; req0_b = b; req0_sel = sel;
    end
    @(posedge clk); #1;
    req0_valid = 1'b0; req1_valid = 1'b0;
    lat = 1;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (rsp_valid) break;
      @(posedge clk); #1;
      if (inj_left > 0) inj_left--;
      lat++;
    end
    if (!rsp_valid) lat = -1;
  endtask

  task automatic finish_rsp();
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({rsp_valid, req0_ready, req1_ready, rsp_id, rsp_data, rsp_carry, rsp_err} !== 13'h0) begin
      failures++; $display("FAIL reset_rsp got=%b exp=0", {rsp_valid, req0_ready, req1_ready, rsp_id, rsp_data, rsp_carry, rsp_err});
    end
    checks++;
    if ({alu_a0, alu_b0, alu_a1, alu_b1, alu_sel1, alu_sel2, fault_sticky, fault_count} !== 45'h0) begin
      failures++; $display("FAIL reset_alu_fault got=%h exp=0", {alu_a0, alu_b0, alu_a1, alu_b1, alu_sel1, alu_sel2, fault_sticky, fault_count});
    end
    rst = 1'b0;
  endtask

  task automatic test_alternate();
    int w;
    req0_valid = 1'b1; req0_a = 8'h10; req0_b = 8'h01; req0_sel = 2'b01;
    req1_valid = 1'b1; req1_a = 8'h01; req1_b = 8'h02; req1_sel = 2'b01;
    rsp_ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      w = 0;
      do begin @(negedge clk); w++; end while (!rsp_valid && w < 12);
      checks++;
      if (w !== ((k == 0) ? 2 : 3)) begin
        failures++; $display("FAIL alt_spacing op=%0d got=%0d exp=%0d", k, w, (k == 0) ? 2 : 3);
      end
      checks++;
      if (rsp_id !== k[0]) begin
        failures++; $display("FAIL alt_id op=%0d got=%b exp=%b", k, rsp_id, k[0]);
      end
      checks++;
      if ({rsp_carry, rsp_data} !== (k[0] ? 9'h1FF : 9'h00F)) begin
        failures++; $display("FAIL alt_data op=%0d got=%h exp=%h", k, {rsp_carry, rsp_data}, k[0] ? 9'h1FF : 9'h00F);
      end
      @(posedge clk);
      if (k == 7) begin
        #1 req0_valid = 1'b0; req1_valid = 1'b0; rsp_ready = 1'b0;
      end
    end
    @(negedge clk);
  endtask

  task automatic test_add();
    int lat;
    do_op(1'b0, 8'hF0, 8'h20, 2'b00, lat);
    checks++;
    if (lat !== 2) begin failures++; $display("FAIL add_latency got=%0d exp=2", lat); end
    checks++;
    if ({rsp_id, rsp_carry, rsp_data, rsp_err, fault_count} !== {1'b0, 1'b1, 8'h10, 1'b0, 8'h00}) begin
      failures++; $display("FAIL add_rsp got=%h exp=%h", {rsp_id, rsp_carry, rsp_data, rsp_err, fault_count}, {1'b0, 1'b1, 8'h10, 1'b0, 8'h00});
    end
    finish_rsp();
    checks++;
    if ({rsp_valid, alu_a0, alu_b1, alu_sel2} !== {1'b0, 8'hF0, 8'h20, 2'b00}) begin
      failures++; $display("FAIL idle_hold got=%h exp=%h", {rsp_valid, alu_a0, alu_b1, alu_sel2}, {1'b0, 8'hF0, 8'h20, 2'b00});
    end
  endtask

  task automatic test_retry_recover();
    int lat;
    inj_mask = 8'h01; inj_left = 1;
    do_op(1'b1, 8'h03, 8'h04, 2'b00, lat);
    checks++;
    if (lat !== 3) begin failures++; $display("FAIL recover_latency got=%0d exp=3", lat); end
    checks++;
    if ({rsp_id, rsp_carry, rsp_data, rsp_err, fault_sticky, fault_count} !== {1'b1, 1'b0, 8'h07, 1'b0, 1'b0, 8'h00}) begin
      failures++; $display("FAIL recover_rsp got=%h exp=%h", {rsp_id, rsp_carry, rsp_data, rsp_err, fault_sticky, fault_count}, {1'b1, 1'b0, 8'h07, 1'b0, 1'b0, 8'h00});
    end
    finish_rsp();
  endtask

  task automatic test_persistent_fault();
    int lat;
    inj_mask = 8'h01; inj_left = 100;
    do_op(1'b0, 8'h55, 8'h0F, 2'b10, lat);
    inj_left = 0;
    checks++;
    if (lat !== 4) begin failures++; $display("FAIL fault_latency got=%0d exp=4", lat); end
    checks++;
    if ({rsp_id, rsp_carry, rsp_data, rsp_err} !== {1'b0, 1'b0, 8'h05, 1'b1}) begin
      failures++; $display("FAIL fault_rsp got=%h exp=%h", {rsp_id, rsp_carry, rsp_data, rsp_err}, {1'b0, 1'b0, 8'h05, 1'b1});
    end
    checks++;
    if ({fault_sticky, fault_count} !== {1'b1, 8'h01}) begin
      failures++; $display("FAIL fault_log got=%h exp=%h", {fault_sticky, fault_count}, {1'b1, 8'h01});
    end
    finish_rsp();
    fault_clr = 1'b1;
    @(posedge clk); #1 fault_clr = 1'b0;
    @(negedge clk);
    checks++;
    if ({fault_sticky, fault_count} !== 9'h000) begin
      failures++; $display("FAIL fault_clear got=%h exp=000", {fault_sticky, fault_count});
    end
  endtask

  task automatic test_backpressure();
    int lat;
    do_op(1'b1, 8'h0C, 8'h30, 2'b11, lat);
    checks++;
    if (lat !== 2) begin failures++; $display("FAIL bp_latency got=%0d exp=2", lat); end
    req0_valid = 1'b1; req0_a = 8'h11; req0_b = 8'h22; req0_sel = 2'b00;
    for (int i = 0; i < 5; i++) begin
      #1;
      checks++;
      if ({rsp_valid, rsp_id, rsp_carry, rsp_data, rsp_err, req0_ready, req1_ready} !== {1'b1, 1'b1, 1'b0, 8'h3C, 1'b0, 1'b0, 1'b0}) begin
        failures++; $display("FAIL bp_hold cyc=%0d got=%h exp=%h", i, {rsp_valid, rsp_id, rsp_carry, rsp_data, rsp_err, req0_ready, req1_ready}, {1'b1, 1'b1, 1'b0, 8'h3C, 1'b0, 1'b0, 1'b0});
      end
      @(negedge clk);
    end
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    checks++;
    if ({rsp_valid, req0_ready} !== 2'b01) begin
      failures++; $display("FAIL bp_release got=%b exp=01", {rsp_valid, req0_ready});
    end
    req0_valid = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset_mid_op();
    int lat;
    req0_valid = 1'b1; req0_a = 8'hAA; req0_b = 8'h55; req0_sel = 2'b00;
    @(posedge clk); #1;
    req0_valid = 1'b0;
    rst = 1'b1;
    #1;
    checks++;
    if ({rsp_valid, alu_a0, alu_b1, rsp_data, fault_count} !== 33'h0) begin
      failures++; $display("FAIL rst_mid got=%h exp=0", {rsp_valid, alu_a0, alu_b1, rsp_data, fault_count});
    end
    @(posedge clk);
    @(negedge clk);
    checks++;
    if (rsp_valid !== 1'b0) begin failures++; $display("FAIL rst_mid_valid got=%b exp=0", rsp_valid); end
    rst = 1'b0;
    do_op(1'b0, 8'h7F, 8'h01, 2'b00, lat);
    checks++;
    if (lat !== 2) begin failures++; $display("FAIL post_rst_latency got=%0d exp=2", lat); end
    checks++;
    if ({rsp_id, rsp_carry, rsp_data, rsp_err} !== {1'b0, 1'b0, 8'h80, 1'b0}) begin
      failures++; $display("FAIL post_rst_rsp got=%h exp=%h", {rsp_id, rsp_carry, rsp_data, rsp_err}, {1'b0, 1'b0, 8'h80, 1'b0});
    end
    finish_rsp();
  endtask

  initial begin
    test_reset();
    test_alternate();
    test_add();
    test_retry_recover();
    test_persistent_fault();
    test_backpressure();
    test_reset_mid_op();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
